// File: rtl/mmio_port_pkg.sv
// Shared register-map constants for the MMIO port responder.
package mmio_port_pkg;

  localparam logic [1:0] OFF_OUT    = 2'd0;
  localparam logic [1:0] OFF_IN     = 2'd1;
  localparam logic [1:0] OFF_STATUS = 2'd2;
  localparam logic [1:0] OFF_CTRL   = 2'd3;

  localparam int unsigned ST_FULL    = 0;
  localparam int unsigned ST_EMPTY   = 1;
  localparam int unsigned ST_CHANGED = 2;
  localparam int unsigned ST_OVF     = 3;
  localparam int unsigned ST_CNT_LSB = 4;
  localparam int unsigned ST_CNT_W   = 5;

  localparam int unsigned CTRL_W1C     = 0;
  localparam int unsigned CTRL_IE      = 1;
  localparam int unsigned CTRL_OE      = 2;
  localparam int unsigned CTRL_PRE_LSB = 8;
  localparam int unsigned CTRL_PRE_W   = 16;

  function automatic logic [31:0] pack_status(input logic full, input logic empty,
                                              input logic changed, input logic ovf,
                                              input logic [ST_CNT_W-1:0] cnt);
    logic [31:0] s;
    s = '0;
    s[ST_FULL]    = full;
    s[ST_EMPTY]   = empty;
    s[ST_CHANGED] = changed;
    s[ST_OVF]     = ovf;
    s[ST_CNT_LSB +: ST_CNT_W] = cnt;
    return s;
  endfunction

endpackage

// File: rtl/io_sync_fifo.sv
// Parameterized synchronous FIFO; accepts a push while full only when a pop happens the same cycle.
module io_sync_fifo #(
  parameter int unsigned Width = 32,
  parameter int unsigned Depth = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [Width-1:0]         data_i,
  output logic [Width-1:0]         data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(Depth):0]   count_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;

  logic [Width-1:0] mem_q [Depth];
  logic [Width-1:0] mem_d [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CntW'(Depth));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];

  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = data_i;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (do_push && !do_pop) begin
      count_d = count_q + 1'b1;
    end else if (do_pop && !do_push) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/mmio_port_responder.sv
// 16-byte MMIO window driving a paced output FIFO and a synchronized input port.
// Define MMIO_PORT_IRQ_EN to add the Irq output and CTRL ie/oe enables.
module mmio_port_responder
  import mmio_port_pkg::*;
#(
  parameter logic [31:0] IO_BASE      = 32'h1001_0000,
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter logic [15:0] PRESCALE_RST = 16'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Address,
  input  logic [31:0] WriteData,
  input  logic        MemWrite,
  input  logic        MemRead,
  output logic [31:0] ReadData,
  output logic        Hit,
  input  logic [7:0]  PortIn,
  output logic [31:0] PortOut
`ifdef MMIO_PORT_IRQ_EN
  ,
  output logic        Irq
`endif
);

  localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;

  logic [1:0]      off;
  logic            wr_en, push, pop, ctrl_wr, w1c, ovf_event;
  logic            fifo_full, fifo_empty;
  logic [CntW-1:0] fifo_count;
  logic [31:0]     fifo_rdata;

  logic [7:0]  sync1_q, sync1_d, in_sync_q, in_sync_d, prev_q, prev_d;
  logic        in_changed_q, in_changed_d, overflow_q, overflow_d;
  logic [15:0] prescale_q, prescale_d, dcnt_q, dcnt_d;
  logic [31:0] portout_q, portout_d;
`ifdef MMIO_PORT_IRQ_EN
  logic        ie_q, ie_d, oe_q, oe_d, irq_q, irq_d;
`endif

  logic unused_bits;
  assign unused_bits = ^{Address[1:0], WriteData[31:24], WriteData[7:1]};

  assign Hit     = (Address[31:4] == IO_BASE[31:4]);
  assign off     = Address[3:2];
  assign wr_en   = MemWrite & Hit;
  assign push    = wr_en & (off == OFF_OUT);
  assign ctrl_wr = wr_en & (off == OFF_CTRL);
  assign w1c     = ctrl_wr & WriteData[CTRL_W1C];
  assign pop     = ~fifo_empty & (dcnt_q == '0);
  // A pop in the same cycle frees a slot, so only a full FIFO without a pop loses data.
  assign ovf_event = push & fifo_full & ~pop;

  io_sync_fifo #(
    .Width(32),
    .Depth(FIFO_DEPTH)
  ) u_fifo (
    .clk_i  (clk),
    .rst_ni (reset),
    .push_i (push),
    .pop_i  (pop),
    .data_i (WriteData),
    .data_o (fifo_rdata),
    .full_o (fifo_full),
    .empty_o(fifo_empty),
    .count_o(fifo_count)
  );

  always_comb begin
    sync1_d   = PortIn;
    in_sync_d = sync1_q;
    prev_d    = in_sync_q;

    in_changed_d = in_changed_q;
    overflow_d   = overflow_q;
    if (w1c) begin
      in_changed_d = 1'b0;
      overflow_d   = 1'b0;
    end
    if (in_sync_q != prev_q) in_changed_d = 1'b1;
    if (ovf_event)           overflow_d   = 1'b1;

    prescale_d = ctrl_wr ? WriteData[CTRL_PRE_LSB +: CTRL_PRE_W] : prescale_q;

    // Reload uses the pre-write prescale so a running countdown is not disturbed.
    dcnt_d    = dcnt_q;
    portout_d = portout_q;
    if (!fifo_empty) begin
      if (dcnt_q == '0) begin
        portout_d = fifo_rdata;
        dcnt_d    = prescale_q;
      end else begin
        dcnt_d = dcnt_q - 16'd1;
      end
    end

`ifdef MMIO_PORT_IRQ_EN
    ie_d  = ctrl_wr ? WriteData[CTRL_IE] : ie_q;
    oe_d  = ctrl_wr ? WriteData[CTRL_OE] : oe_q;
    irq_d = (ie_d & in_changed_d) | (oe_d & overflow_d);
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q      <= '0;
      in_sync_q    <= '0;
      prev_q       <= '0;
      in_changed_q <= 1'b0;
      overflow_q   <= 1'b0;
      prescale_q   <= PRESCALE_RST;
      dcnt_q       <= '0;
      portout_q    <= '0;
`ifdef MMIO_PORT_IRQ_EN
      ie_q         <= 1'b0;
      oe_q         <= 1'b0;
      irq_q        <= 1'b0;
`endif
    end else begin
      sync1_q      <= sync1_d;
      in_sync_q    <= in_sync_d;
      prev_q       <= prev_d;
      in_changed_q <= in_changed_d;
      overflow_q   <= overflow_d;
      prescale_q   <= prescale_d;
      dcnt_q       <= dcnt_d;
      portout_q    <= portout_d;
`ifdef MMIO_PORT_IRQ_EN
      ie_q         <= ie_d;
      oe_q         <= oe_d;
      irq_q        <= irq_d;
`endif
    end
  end

  assign PortOut = portout_q;
`ifdef MMIO_PORT_IRQ_EN
  assign Irq = irq_q;
`endif

  always_comb begin
    ReadData = '0;
    if (MemRead && Hit) begin
      case (off)
        OFF_OUT:    ReadData = portout_q;
        OFF_IN:     ReadData = {24'b0, in_sync_q};
        OFF_STATUS: ReadData = pack_status(fifo_full, fifo_empty, in_changed_q, overflow_q,
                                           ST_CNT_W'(fifo_count));
        default: begin
          ReadData[CTRL_PRE_LSB +: CTRL_PRE_W] = prescale_q;
`ifdef MMIO_PORT_IRQ_EN
          ReadData[CTRL_IE] = ie_q;
          ReadData[CTRL_OE] = oe_q;
`endif
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_port_responder.sv
// Directed table plus hand-written sequences for mmio_port_responder.
module tb_mmio_port_responder;

  localparam logic [31:0] BASE = 32'h1001_0000;
  localparam logic [31:0] A_OUT = BASE + 32'h0;
  localparam logic [31:0] A_IN  = BASE + 32'h4;
  localparam logic [31:0] A_ST  = BASE + 32'h8;
  localparam logic [31:0] A_CT  = BASE + 32'hC;
`ifdef MMIO_PORT_IRQ_EN
  localparam logic [31:0] CTRL_RB = 32'h0012_3406;
`else
  localparam logic [31:0] CTRL_RB = 32'h0012_3400;
`endif

  logic        clk, reset;
  logic [31:0] Address, WriteData, ReadData, PortOut;
  logic        MemWrite, MemRead, Hit;
  logic [7:0]  PortIn;
`ifdef MMIO_PORT_IRQ_EN
  logic        Irq;
`endif

  int checks = 0;
  int errors = 0;

  mmio_port_responder #(
    .IO_BASE(BASE),
    .FIFO_DEPTH(4),
    .PRESCALE_RST(16'd0)
  ) dut (
    .clk(clk),
    .reset(reset),
    .Address(Address),
    .WriteData(WriteData),
    .MemWrite(MemWrite),
    .MemRead(MemRead),
    .ReadData(ReadData),
    .Hit(Hit),
    .PortIn(PortIn),
    .PortOut(PortOut)
`ifdef MMIO_PORT_IRQ_EN
    ,
    .Irq(Irq)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic        re;
    logic        hit;
    logic [31:0] rdata;
  } vec_t;

  localparam int NV = 14;
  vec_t tbl [NV];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    Address   = a;
    WriteData = d;
    MemWrite  = 1'b1;
    MemRead   = 1'b0;
    tick();
    MemWrite  = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    Address = a;
    MemRead = 1'b1;
    #1;
    d       = ReadData;
    MemRead = 1'b0;
  endtask

  task automatic chk_rd(input string nm, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] d;
    rd(a, d);
    chk(nm, d, exp);
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    #2;
    reset = 1'b1;
  endtask

  function automatic logic [31:0] drain_exp(input int k);
    if (k < 1) return 32'h0;
    if (k < 5) return 32'hA;
    if (k < 9) return 32'hB;
    return 32'hC;
  endfunction

  initial begin
    reset = 1'b0; Address = '0; WriteData = '0; MemWrite = 1'b0; MemRead = 1'b0; PortIn = 8'h00;

    //                addr          we    wdata          re    hit   rdata
    tbl[0]  = '{A_OUT,           1'b0, 32'h0,         1'b1, 1'b1, 32'h0};
    tbl[1]  = '{A_IN,            1'b0, 32'h0,         1'b1, 1'b1, 32'h0};
    tbl[2]  = '{A_ST,            1'b0, 32'h0,         1'b1, 1'b1, 32'h2};
    tbl[3]  = '{A_CT,            1'b0, 32'h0,         1'b1, 1'b1, 32'h0};
    tbl[4]  = '{A_ST,            1'b0, 32'h0,         1'b0, 1'b1, 32'h0};
    tbl[5]  = '{BASE + 32'h10,   1'b1, 32'h55,        1'b0, 1'b0, 32'h0};
    tbl[6]  = '{A_IN,            1'b1, 32'h77,        1'b0, 1'b1, 32'h0};
    tbl[7]  = '{A_ST,            1'b1, 32'hFFFF,      1'b1, 1'b1, 32'h2};
    tbl[8]  = '{A_ST,            1'b0, 32'h0,         1'b1, 1'b1, 32'h2};
    tbl[9]  = '{BASE + 32'h13,   1'b0, 32'h0,         1'b1, 1'b0, 32'h0};
    tbl[10] = '{BASE + 32'hF,    1'b1, 32'h0012_3407, 1'b0, 1'b1, 32'h0};
    tbl[11] = '{A_CT + 32'h1,    1'b0, 32'h0,         1'b1, 1'b1, CTRL_RB};
    tbl[12] = '{A_CT,            1'b1, 32'h0,         1'b0, 1'b1, 32'h0};
    tbl[13] = '{BASE - 32'h4,    1'b0, 32'h0,         1'b1, 1'b0, 32'h0};

    #12 reset = 1'b1;
    tick();
    chk("reset_portout", PortOut, 32'h0);
    chk_rd("reset_status", A_ST, 32'h2);

    for (int i = 0; i < NV; i++) begin
      Address   = tbl[i].addr;
      WriteData = tbl[i].wdata;
      MemWrite  = tbl[i].we;
      MemRead   = tbl[i].re;
      #1;
      chk($sformatf("vec%0d_hit", i), 32'(Hit), 32'(tbl[i].hit));
      chk($sformatf("vec%0d_rdata", i), ReadData, tbl[i].rdata);
      tick();
      MemWrite = 1'b0;
      MemRead  = 1'b0;
    end
    chk_rd("decode_count_zero", A_ST, 32'h2);

    // Paced drain, prescale 3.
    wr(A_CT, 32'h0000_0300);
    wr(A_OUT, 32'hA);
    chk("drain_k0", PortOut, drain_exp(0));
    wr(A_OUT, 32'hB);
    chk("drain_k1", PortOut, drain_exp(1));
    wr(A_OUT, 32'hC);
    chk("drain_k2", PortOut, drain_exp(2));
    for (int k = 3; k <= 11; k++) begin
      tick();
      chk($sformatf("drain_k%0d", k), PortOut, drain_exp(k));
    end
    chk_rd("drain_empty", A_ST, 32'h2);

    // Reset while entries are still queued.
    wr(A_OUT, 32'hD);
    wr(A_OUT, 32'hE);
    reset = 1'b0;
    #1;
    chk("midreset_portout", PortOut, 32'h0);
    chk_rd("midreset_status", A_ST, 32'h2);
    reset = 1'b1;
    chk_rd("midreset_ctrl", A_CT, 32'h0);

    // Overflow with a long countdown in flight.
    tick();
    wr(A_CT, 32'h00FF_FF00);
    wr(A_OUT, 32'h1);
    wr(A_OUT, 32'h2);
    chk("ovf_first_pop", PortOut, 32'h1);
    wr(A_OUT, 32'h3);
    wr(A_OUT, 32'h4);
    wr(A_OUT, 32'h5);
    wr(A_OUT, 32'h6);
    chk_rd("ovf_status", A_ST, 32'h49);
    chk_rd("ovf_ctrl_rb", A_CT, 32'h00FF_FF00);
    wr(A_CT, 32'h00FF_FF01);
    chk_rd("ovf_cleared", A_ST, 32'h41);

    // Push into a full FIFO in the same cycle as a pop.
    pulse_reset();
    tick();
    wr(A_CT, 32'h0000_0200);
    for (int i = 1; i <= 6; i++) wr(A_OUT, 32'(i));
    chk_rd("fullpop_pre_status", A_ST, 32'h41);
    chk("fullpop_pre_out", PortOut, 32'h2);
    tick();
    wr(A_OUT, 32'h7);
    chk_rd("fullpop_status", A_ST, 32'h41);
    chk("fullpop_out", PortOut, 32'h3);
    for (int i = 0; i < 12; i++) tick();
    chk("fullpop_last", PortOut, 32'h7);
    chk_rd("fullpop_empty", A_ST, 32'h2);

    // Input synchronizer and change flag.
    pulse_reset();
    tick();
    PortIn = 8'h5A;
    tick();
    chk_rd("sync_e1_in", A_IN, 32'h0);
    tick();
    chk_rd("sync_e2_in", A_IN, 32'h5A);
    chk_rd("sync_e2_status", A_ST, 32'h2);
    tick();
    chk_rd("sync_e3_status", A_ST, 32'h6);
    PortIn = 8'h5B;
    tick();
    tick();
    wr(A_CT, 32'h1);
    chk_rd("sync_setwins", A_ST, 32'h6);
    chk_rd("sync_in_5b", A_IN, 32'h5B);
    wr(A_CT, 32'h1);
    chk_rd("sync_cleared", A_ST, 32'h2);

`ifdef MMIO_PORT_IRQ_EN
    PortIn = 8'h00;
    pulse_reset();
    tick();
    wr(A_CT, 32'h2);
    PortIn = 8'h11;
    tick();
    tick();
    chk("irq_before", 32'(Irq), 32'h0);
    tick();
    chk("irq_set", 32'(Irq), 32'h1);
    chk_rd("irq_status", A_ST, 32'h6);
    wr(A_CT, 32'h3);
    chk("irq_cleared", 32'(Irq), 32'h0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
